fft_reorder: RTL and testbench
==============================

# fft_reorder

Bit-reversal reorder buffer at the output of the 8-point FFT datapath. It accepts complex samples in bit-reversed index order with a valid/ready handshake. It emits them in natural index order, one frame at a time, through a valid/ready handshake. Two banks used as ping-pong buffers let frame k+1 be written while frame k is read, so it sustains one sample per cycle at full rate.

## Interface
- DATA_WIDTH, 16, width of each signed real/imag component
- N_POINTS, 8, frame length; power of two, ≥2
- clk  input  1  rising-edge clock
- arst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input sample present
- in_ready  output  1  block can accept a sample this cycle
- in_re  input  DATA_WIDTH  signed real part
- in_im  input  DATA_WIDTH  signed imaginary part
- out_valid  output  1  output sample present
- out_ready  input  1  downstream accepts sample
- out_re  output  DATA_WIDTH  signed real part, natural order
- out_im  output  DATA_WIDTH  signed imaginary part, natural order
- out_last  output  1  high with the final sample (index N_POINTS-1) of a frame

## Operation
- A sample is accepted when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Storage is two banks of N_POINTS entries × 2·DATA_WIDTH flops. Each bank has its own state: EMPTY → FILLING → FULL → DRAINING → EMPTY.
- Write side: write bank pointer wb and write counter wcnt (log2(N_POINTS) bits).
  - Each accept stores the sample at address bitrev(wcnt) in bank wb, then increments wcnt.
  - On wcnt == N_POINTS-1: bank wb goes FULL, wcnt wraps to 0, and wb toggles.
- in_ready = 1 when bank wb is EMPTY or FILLING; 0 when it is FULL or DRAINING.
- Read side: read bank pointer rb and read counter rcnt.
  - out_valid = 1 when bank rb is FULL or DRAINING.
  - out_re/out_im = bank rb entry rcnt.
  - out_last = out_valid && rcnt == N_POINTS-1.
  - Each transfer increments rcnt. On the last transfer, bank rb goes EMPTY, rcnt wraps, and rb toggles.
- Data is held stable while out_valid && !out_ready.
- Simultaneous events:
  - A write completing bank A and a read completing bank B in the same cycle both take effect. Both pointers toggle.
  - A write into a bank whose last read happens in the same cycle is not possible: in_ready was 0 that cycle. The bank is writable from the next cycle.
- Arithmetic: no arithmetic on data. Counters wrap modulo N_POINTS. bitrev reverses log2(N_POINTS) bits.
- Reset, including mid-frame: all bank states EMPTY; wb = rb = 0; wcnt = rcnt = 0; storage cleared to 0. Any partial frame is discarded.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_re = 0, out_im = 0, out_last = 0.
- Latency: the first output is valid in the cycle after the N_POINTS-th input of a frame is accepted. This is a registered state update; outputs are read combinationally from the flop array.
- Throughput: with out_ready held high and continuous input, in_ready never deasserts after the first frame, and out_valid is continuous.
- Backpressure: if both banks are FULL/DRAINING, in_ready = 0 until the draining bank emits out_last.
- No combinational path from in_valid to in_ready, nor from out_ready to out_valid.

## Configuration
- FFT_REORDER_BITREV_EN defined: write address is bitrev(wcnt), giving the reorder behaviour described above.
- Undefined: write address is wcnt. The block becomes a two-frame ping-pong buffer that preserves input order, for natural-order FFT variants. Handshake, latency and out_last are identical in both builds.

## Structure
- Shared package fft_pkg holds:
  - N_POINTS_DEFAULT and LOG2_N
  - the bank_state_t enum (EMPTY, FILLING, FULL, DRAINING)
  - function bitrev(idx, width)
- Sub-module reorder_bank, instantiated twice: one bank's storage, write port (addr, data, we) and read mux (addr → data), reset to zero.
- fft_reorder holds counters, bank pointers, bank state machines and handshake logic.

## Test plan
- Single frame with FFT_REORDER_BITREV_EN, out_ready = 1:
  - in_re = 0,4,2,6,1,5,3,7; in_im = -in_re.
  - Expect out_re = 0..7 and out_im = 0..-7 starting the cycle after the 8th accept.
  - out_last high only on value 7.
- Back-to-back frames, in_valid and out_ready held high for 4 frames:
  - in_ready stays 1 throughout; out_valid is continuous from cycle 9.
  - Expect 32 outputs in order, with out_last every 8th.
- Backpressure, out_ready = 0 while 3 frames are offered:
  - in_ready drops after 16 accepts; out_re/out_im hold 0 then.
  - Raise out_ready: frame 1 drains; in_ready returns the cycle after its out_last.
- Random in_valid/out_ready (50%) over 100 frames: outputs equal the reference reordering, with no loss or duplication.
- Reset mid-frame, asserting arst_n low after 3 accepts of frame 2:
  - Outputs immediately show out_valid = 0, in_ready = 1.
  - A new frame after reset is reordered correctly.
- Build without the macro: in_re = 0,4,2,6,1,5,3,7 → out_re = 0,4,2,6,1,5,3,7, same latency.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
package fft_pkg;

  localparam int N_POINTS_DEFAULT = 8;
  localparam int LOG2_N           = $clog2(N_POINTS_DEFAULT);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Reverses the low `width` bits of idx; bits above width are returned as 0.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = idx[5'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One frame of sample storage: single write port, combinational read mux, cleared on reset.
module reorder_bank
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = N_POINTS_DEFAULT,
  parameter int AW         = LOG2_N
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    we_i,
  input  logic [AW-1:0]           waddr_i,
  input  logic [2*DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]           raddr_i,
  output logic [2*DATA_WIDTH-1:0] rdata_o
);

  logic [2*DATA_WIDTH-1:0] mem_q [N_POINTS];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N_POINTS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer converting bit-reversed FFT output to natural order.
// Define FFT_REORDER_BITREV_EN for bit-reversed write addressing; otherwise input order is kept.
module fft_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = N_POINTS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic                  out_last
);

  localparam int AW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);

  bank_state_t             st_q [2];
  bank_state_t             st_d [2];
  logic                    wb_q, wb_d, rb_q, rb_d;
  logic [AW-1:0]           wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [AW-1:0]           waddr;
  logic [2*DATA_WIDTH-1:0] rdata [2];
  logic                    wr_fire, rd_fire;

  // Handshake flags depend only on registered state, never on the partner's valid/ready.
  assign in_ready  = (st_q[wb_q] == EMPTY) || (st_q[wb_q] == FILLING);
  assign out_valid = (st_q[rb_q] == FULL)  || (st_q[rb_q] == DRAINING);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

`ifdef FFT_REORDER_BITREV_EN
  assign waddr = AW'(bitrev(32'(wcnt_q), AW));
`else
  assign waddr = wcnt_q;
`endif

  assign {out_re, out_im} = rdata[rb_q];
  assign out_last         = out_valid && (rcnt_q == LAST_IDX);

  // A bank being written is EMPTY/FILLING and one being read is FULL/DRAINING,
  // so the two updates below never target the same bank in one cycle.
  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    wb_d    = wb_q;
    rb_d    = rb_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    if (wr_fire) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == LAST_IDX) begin
        st_d[wb_q] = FULL;
        wcnt_d     = '0;
        wb_d       = ~wb_q;
      end else begin
        st_d[wb_q] = FILLING;
      end
    end
    if (rd_fire) begin
      rcnt_d = rcnt_q + 1'b1;
      if (rcnt_q == LAST_IDX) begin
        st_d[rb_q] = EMPTY;
        rcnt_d     = '0;
        rb_d       = ~rb_q;
      end else begin
        st_d[rb_q] = DRAINING;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    reorder_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .N_POINTS  (N_POINTS),
      .AW        (AW)
    ) u_bank (
      .clk    (clk),
      .arst_n (arst_n),
      .we_i   (wr_fire && (wb_q == 1'(gi))),
      .waddr_i(waddr),
      .wdata_i({in_re, in_im}),
      .raddr_i(rcnt_q),
      .rdata_o(rdata[gi])
    );
  end

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder: directed frames, backpressure, random handshakes, mid-frame reset.
module tb_fft_reorder;

  localparam int DW = 16;
  localparam int N  = 8;
`ifdef FFT_REORDER_BITREV_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          in_ready, out_valid, out_last;
  logic [DW-1:0] out_re, out_im;

  fft_reorder #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] src_q [$];   // samples still to offer, {re, im}
  logic [31:0] part_q [$];  // accepted samples of the frame being collected
  logic [32:0] exp_q [$];   // expected outputs of complete frames, {last, re, im}

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Index with its three bits read in reverse order.
  function automatic int brev(input int p);
    int r = 0;
    int v = p;
    for (int b = 0; b < 3; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // One clock: drive at negedge, check against the model, then update the model at posedge.
  task automatic step(input bit want, input bit ordy);
    bit acc, xfer;
    int held;
    @(negedge clk);
    in_valid = want && (src_q.size() > 0);
    if (in_valid) {in_re, in_im} = src_q[0];
    out_ready = ordy;
    #1;
    held = (exp_q.size() + N - 1) / N;
    chk("in_ready", in_ready, held < 2);
    chk("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) chk("out_data", {out_last, out_re, out_im}, exp_q[0]);
    $display("t=%0t iv=%0b ir=%0b ov=%0b or=%0b re=%0d im=%0d last=%0b",
             $time, in_valid, in_ready, out_valid, out_ready,
             $signed(out_re), $signed(out_im), out_last);
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    @(posedge clk);
    if (xfer && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) begin
      part_q.push_back(src_q.pop_front());
      if (part_q.size() == N) begin
        for (int n = 0; n < N; n++) exp_q.push_back({n == N - 1, part_q[BR ? brev(n) : n]});
        part_q.delete();
      end
    end
  endtask

  task automatic run(input int maxc, input int pv, input int pr);
    int c = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && c < maxc) begin
      step($urandom_range(99) < pv, $urandom_range(99) < pr);
      c++;
    end
    chk("drain_done", 33'(src_q.size() + exp_q.size()), 33'd0);
  endtask

  task automatic push_directed();
    int dir [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic signed [DW-1:0] r;
    for (int i = 0; i < N; i++) begin
      r = DW'(dir[i]);
      src_q.push_back({r, -r});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_last"}, out_last, 1'b0);
    chk({tag, "_out_data"}, {out_re, out_im}, 32'd0);
  endtask

  initial begin
    // Power-on reset
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    // Single directed frame, downstream always ready
    push_directed();
    run(40, 100, 100);

    // Four back-to-back frames at full rate
    for (int i = 0; i < 4 * N; i++) src_q.push_back($urandom);
    run(80, 100, 100);

    // Backpressure: three frames offered with downstream stalled, then released
    for (int i = 0; i < 3 * N; i++) src_q.push_back($urandom);
    repeat (30) step(1'b1, 1'b0);
    run(200, 100, 100);

    // Random valid/ready over 100 frames
    for (int i = 0; i < 100 * N; i++) src_q.push_back($urandom);
    run(20000, 50, 50);

    // Reset after one full frame plus three samples of the next
    for (int i = 0; i < N + 3; i++) src_q.push_back($urandom);
    repeat (N + 3) step(1'b1, 1'b0);
    @(negedge clk);
    arst_n   = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    src_q.delete();
    part_q.delete();
    exp_q.delete();
    @(negedge clk);
    arst_n = 1'b1;

    // Frame after reset reorders correctly
    push_directed();
    run(40, 100, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
